dmac_write_scheduler: RTL and testbench

//  Per-channel write-side scheduler of the DMA controller. Accepts one write descriptor
//  (dst addr, beat count) per channel, splits it into AXI4 INCR bursts (<=MAX_BURST_LEN

---
 rtl/dmac_write_scheduler.sv | 147 ++++++++++++++
 tb/tb_dmac_write_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_write_scheduler.sv
// dmac_write_scheduler: per-channel DMA write-side scheduler.
// Each channel holds one descriptor (dst address, beat count). The descriptor is
// cut into AXI4 INCR bursts of at most MAX_BURST_LEN beats that never cross a
// 4KB page. The single write initiator is shared round-robin, one burst per grant.
module dmac_write_scheduler #(
  parameter int ADDR_WD       = 32,
  parameter int DATA_WD       = 32,
  parameter int CHANNEL_COUNT = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WD        = 16,
  localparam int BYTES        = DATA_WD / 8,
  localparam int SZ_WD        = $clog2(BYTES),
  localparam int CH_WD        = $clog2(CHANNEL_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CHANNEL_COUNT-1:0]         ch_req_valid,
  output logic [CHANNEL_COUNT-1:0]         ch_req_ready,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0] ch_req_addr,
  input  logic [CHANNEL_COUNT*LEN_WD-1:0]  ch_req_beats,
  output logic [CHANNEL_COUNT-1:0]         ch_done,
  output logic                             wr_req_valid,
  input  logic                             wr_req_ready,
  output logic [ADDR_WD-1:0]               wr_req_addr,
  output logic [7:0]                       wr_req_len,
  output logic [2:0]                       wr_req_size,
  output logic [1:0]                       wr_req_burst,
  output logic [SZ_WD-1:0]                 wr_req_data_offset,
  output logic                             wr_req_last,
  output logic [CH_WD-1:0]                 wr_req_chan,
  output logic                             busy
);

  // Burst-size arithmetic must hold both a full beat count (LEN_WD+1) and 4096.
  localparam int CW = (LEN_WD + 1 > 13) ? LEN_WD + 1 : 13;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]               state;
  logic [CHANNEL_COUNT-1:0] active;
  logic [CHANNEL_COUNT-1:0] done_q;
  logic [ADDR_WD-1:0]       addr_q [CHANNEL_COUNT];
  logic [LEN_WD-1:0]        rem_q  [CHANNEL_COUNT];
  logic [CH_WD-1:0]         rr;
  logic [CW-1:0]            n_q;

  logic                     pick_found;
  logic [CH_WD-1:0]         pick;
  logic [CH_WD-1:0]         cand;
  logic [12:0]              page_bytes;
  logic [CW-1:0]            page_beats;
  logic [CW-1:0]            n_beats;
  logic                     n_last;

  assign ch_req_ready       = ~active;
  assign ch_done            = done_q;
  assign busy               = (|active) | wr_req_valid;
  assign wr_req_size        = 3'(SZ_WD);
  assign wr_req_burst       = 2'b01;
  assign wr_req_data_offset = '0;

  // Round-robin pick: first active channel at or after the RR pointer.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int unsigned k = 0; k < CHANNEL_COUNT; k++) begin
      cand = CH_WD'((32'(rr) + k) % 32'(CHANNEL_COUNT));
      if (!pick_found && active[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  // Size the next burst of the picked channel: min(remaining, max burst, room to 4KB).
  always_comb begin
    page_bytes = 13'h1000 - {1'b0, addr_q[pick][11:0]};
    page_beats = CW'(page_bytes >> SZ_WD);
    n_beats    = CW'(rem_q[pick]);
    if (n_beats > CW'(MAX_BURST_LEN)) n_beats = CW'(MAX_BURST_LEN);
    if (n_beats > page_beats)         n_beats = page_beats;
    n_last     = (n_beats == CW'(rem_q[pick]));
  end

  // Channel contexts, arbitration FSM and registered burst request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      active       <= '0;
      done_q       <= '0;
      rr           <= '0;
      n_q          <= '0;
      wr_req_valid <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_len   <= '0;
      wr_req_last  <= 1'b0;
      wr_req_chan  <= '0;
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
        addr_q[i] <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      done_q <= '0;
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
        if (ch_req_valid[i] && !active[i]) begin
          if (ch_req_beats[i*LEN_WD +: LEN_WD] == '0) begin
            done_q[i] <= 1'b1;
          end else begin
            active[i] <= 1'b1;
            addr_q[i] <= ch_req_addr[i*ADDR_WD +: ADDR_WD];
            rem_q[i]  <= ch_req_beats[i*LEN_WD +: LEN_WD];
          end
        end
      end
      case (state)
        IDLE: begin
          if (pick_found) begin
            state        <= ISSUE;
            wr_req_valid <= 1'b1;
            wr_req_addr  <= addr_q[pick];
            wr_req_len   <= 8'(n_beats - CW'(1));
            wr_req_last  <= n_last;
            wr_req_chan  <= pick;
            n_q          <= n_beats;
          end
        end
        default: begin
          if (wr_req_ready) begin
            state                <= IDLE;
            wr_req_valid         <= 1'b0;
            wr_req_last          <= 1'b0;
            addr_q[wr_req_chan]  <= addr_q[wr_req_chan] + (ADDR_WD'(n_q) << SZ_WD);
            rem_q[wr_req_chan]   <= rem_q[wr_req_chan] - LEN_WD'(n_q);
            rr <= (wr_req_chan == CH_WD'(CHANNEL_COUNT - 1)) ? '0 : wr_req_chan + CH_WD'(1);
            if (wr_req_last) begin
              active[wr_req_chan] <= 1'b0;
              done_q[wr_req_chan] <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_write_scheduler.sv
// Scoreboard bench for dmac_write_scheduler: descriptor handshakes push the
// expected bursts (computed from address/beat arithmetic) into a queue; a
// monitor on the falling edge checks every presented burst, its RR owner,
// hold-while-stalled, ch_done timing and busy.
module tb_dmac_write_scheduler;
  localparam int CH = 8;
  localparam int AW = 32;
  localparam int LW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    ch_req_valid;
  logic [CH-1:0]    ch_req_ready;
  logic [CH*AW-1:0] ch_req_addr;
  logic [CH*LW-1:0] ch_req_beats;
  logic [CH-1:0]    ch_done;
  logic             wr_req_valid;
  logic             wr_req_ready;
  logic [AW-1:0]    wr_req_addr;
  logic [7:0]       wr_req_len;
  logic [2:0]       wr_req_size;
  logic [1:0]       wr_req_burst;
  logic [1:0]       wr_req_data_offset;
  logic             wr_req_last;
  logic [2:0]       wr_req_chan;
  logic             busy;

  dmac_write_scheduler #(
    .ADDR_WD(AW), .DATA_WD(32), .CHANNEL_COUNT(CH), .MAX_BURST_LEN(16), .LEN_WD(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_req_addr(ch_req_addr), .ch_req_beats(ch_req_beats), .ch_done(ch_done),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_req_size(wr_req_size),
    .wr_req_burst(wr_req_burst), .wr_req_data_offset(wr_req_data_offset),
    .wr_req_last(wr_req_last), .wr_req_chan(wr_req_chan), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  chan;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } burst_t;

  int          checks = 0;
  int          errors = 0;
  burst_t      exp_q[$];
  burst_t      log_q[$];
  logic [CH-1:0] due = '0;
  int unsigned rr_m = 0;
  bit          expect_valid = 0;
  int unsigned pred_chan = 0;
  bit          presented = 0;
  logic [43:0] snap;
  int          done_cnt[CH];
  int          ready_mode = 0;

  task automatic chk(input bit ok, input string name, input longint unsigned act,
                     input longint unsigned exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected burst list of one descriptor, straight from the splitting rules.
  function automatic void model_desc(int unsigned c, logic [31:0] a, int unsigned beats);
    longint unsigned ad = a;
    int unsigned rem = beats;
    int unsigned room, n;
    burst_t b;
    while (rem > 0) begin
      room = (4096 - int'(ad % 4096)) / 4;
      n = rem;
      if (n > 16) n = 16;
      if (n > room) n = room;
      b.chan = 3'(c);
      b.addr = ad[31:0];
      b.len  = 8'(n - 1);
      b.last = (n == rem);
      exp_q.push_back(b);
      ad  += 4 * n;
      rem -= n;
    end
  endfunction

  function automatic int find_idx(int unsigned c);
    foreach (exp_q[j]) if (exp_q[j].chan == 3'(c)) return j;
    return -1;
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin : mon
    int idx;
    int unsigned c;
    burst_t e;
    if (rst) begin
      exp_q.delete();
      due          = '0;
      rr_m         = 0;
      expect_valid = 0;
      presented    = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (due[i] || ch_done[i]) chk(ch_done[i] == due[i], "ch_done", ch_done[i], due[i]);
        if (ch_done[i]) done_cnt[i]++;
      end
      due = '0;
      chk(busy == (exp_q.size() != 0 || wr_req_valid), "busy", busy,
          (exp_q.size() != 0 || wr_req_valid));
      if (!presented && (expect_valid || wr_req_valid))
        chk(wr_req_valid == expect_valid, "burst_presence", wr_req_valid, expect_valid);
      if (wr_req_valid) begin
        if (!presented) begin
          if (expect_valid) chk(wr_req_chan == 3'(pred_chan), "rr_chan", wr_req_chan, pred_chan);
          idx = find_idx(wr_req_chan);
          chk(idx >= 0, "burst_owner", wr_req_chan, 0);
          if (idx >= 0) begin
            e = exp_q[idx];
            chk({wr_req_addr, wr_req_len, wr_req_last} == {e.addr, e.len, e.last},
                "burst_fields", {wr_req_addr, wr_req_len, wr_req_last}, {e.addr, e.len, e.last});
          end
          chk({wr_req_size, wr_req_burst, wr_req_data_offset} == 7'b010_01_00, "burst_const",
              {wr_req_size, wr_req_burst, wr_req_data_offset}, 7'b010_01_00);
          snap = {wr_req_chan, wr_req_addr, wr_req_len, wr_req_last};
          presented = 1;
        end else begin
          chk(snap == {wr_req_chan, wr_req_addr, wr_req_len, wr_req_last}, "hold_stable",
              {wr_req_chan, wr_req_addr, wr_req_len, wr_req_last}, snap);
        end
        if (wr_req_ready) begin
          log_q.push_back({wr_req_chan, wr_req_addr, wr_req_len, wr_req_last});
          idx = find_idx(wr_req_chan);
          if (idx >= 0) begin
            if (exp_q[idx].last) due[wr_req_chan] = 1'b1;
            exp_q.delete(idx);
          end
          rr_m = (int'(wr_req_chan) + 1) % CH;
          presented = 0;
        end
        expect_valid = 0;
      end else begin
        expect_valid = 0;
        for (int k = 0; k < CH; k++) begin
          c = (rr_m + k) % CH;
          if (!expect_valid && find_idx(c) >= 0) begin
            expect_valid = 1;
            pred_chan = c;
          end
        end
      end
      for (int i = 0; i < CH; i++) begin
        if (ch_req_valid[i] && ch_req_ready[i]) begin
          if (ch_req_beats[i*LW +: LW] == 0) due[i] = 1'b1;
          else model_desc(i, ch_req_addr[i*AW +: AW], ch_req_beats[i*LW +: LW]);
        end
      end
    end
  end

  // Initiator ready: 0 = always high, 1 = random, 2 = held low.
  initial begin
    wr_req_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       wr_req_ready = 1'b1;
        1:       wr_req_ready = ($urandom_range(0, 3) != 0);
        default: wr_req_ready = 1'b0;
      endcase
    end
  end

  task automatic set_desc(input int c, input logic [31:0] a, input int unsigned beats);
    ch_req_valid[c]        = 1'b1;
    ch_req_addr[c*AW +: AW] = a;
    ch_req_beats[c*LW +: LW] = LW'(beats);
  endtask

  // One cycle: drop descriptor valids that handshake at the coming edge.
  task automatic step();
    logic [CH-1:0] acc;
    @(negedge clk);
    acc = ch_req_valid & ch_req_ready;
    @(posedge clk);
    #1;
    ch_req_valid = ch_req_valid & ~acc;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0 || ch_req_valid != 0) && t < 5000) begin
      step();
      t++;
    end
    repeat (2) step();
    chk(t < 5000, "idle_timeout", t, 5000);
  endtask

  task automatic chk_log(input int i, input int c, input logic [31:0] a,
                         input int l, input bit last);
    burst_t b;
    chk(log_q.size() > i, "log_len", log_q.size(), i + 1);
    if (log_q.size() > i) begin
      b = log_q[i];
      chk(b == {3'(c), a, 8'(l), last}, "log_burst", b, {3'(c), a, 8'(l), last});
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    ch_req_valid = '0;
    ch_req_addr  = '0;
    ch_req_beats = '0;
    foreach (done_cnt[i]) done_cnt[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(ch_req_ready == '1, "rst_ready", ch_req_ready, 8'hFF);
    chk(ch_done == '0, "rst_done", ch_done, 0);
    chk(wr_req_valid == 1'b0, "rst_valid", wr_req_valid, 0);
    chk(wr_req_last == 1'b0, "rst_last", wr_req_last, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 40 beats from 0x1000: 16 + 16 + 8.
    log_q.delete();
    set_desc(0, 32'h1000, 40);
    wait_idle();
    chk(log_q.size() == 3, "t1_count", log_q.size(), 3);
    chk_log(0, 0, 32'h1000, 15, 0);
    chk_log(1, 0, 32'h1040, 15, 0);
    chk_log(2, 0, 32'h1080, 7, 1);
    chk(done_cnt[0] == 1, "t1_done_cnt", done_cnt[0], 1);

    // 4KB boundary split.
    log_q.delete();
    set_desc(0, 32'h0FF0, 8);
    wait_idle();
    chk(log_q.size() == 2, "t2_count", log_q.size(), 2);
    chk_log(0, 0, 32'h0FF0, 3, 0);
    chk_log(1, 0, 32'h1000, 3, 1);

    // Three channels in the same cycle: round-robin interleave.
    log_q.delete();
    set_desc(1, 32'h2000, 32);
    set_desc(3, 32'h3000, 32);
    set_desc(5, 32'h5000, 32);
    wait_idle();
    chk(log_q.size() == 6, "t3_count", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      chk(log_q[i].chan == 3'(1 + 2 * (i % 3)), "t3_rr", log_q[i].chan, 1 + 2 * (i % 3));
    chk(done_cnt[1] == 1 && done_cnt[3] == 1 && done_cnt[5] == 1, "t3_done",
        {done_cnt[1][3:0], done_cnt[3][3:0], done_cnt[5][3:0]}, 12'h111);

    // Initiator stalls 5 cycles while a burst is offered.
    log_q.delete();
    ready_mode = 2;
    set_desc(4, 32'h4000, 8);
    t = 0;
    while (!wr_req_valid && t < 50) begin step(); t++; end
    chk(t < 50, "t4_valid_timeout", t, 50);
    repeat (5) step();
    @(negedge clk);
    chk(wr_req_valid == 1'b1, "t4_still_valid", wr_req_valid, 1);
    chk(log_q.size() == 0, "t4_no_accept", log_q.size(), 0);
    ready_mode = 0;
    wait_idle();
    chk(log_q.size() == 1, "t4_count", log_q.size(), 1);

    // Zero-beat descriptor: ch_done only, no burst.
    log_q.delete();
    set_desc(2, 32'h0100, 0);
    wait_idle();
    chk(log_q.size() == 0, "t5_no_burst", log_q.size(), 0);
    chk(done_cnt[2] == 1, "t5_done_cnt", done_cnt[2], 1);

    // Reset while a burst is pending and two channels are active.
    ready_mode = 2;
    set_desc(0, 32'h8000, 64);
    set_desc(6, 32'h9000, 64);
    t = 0;
    while (!wr_req_valid && t < 50) begin step(); t++; end
    chk(t < 50, "t6_valid_timeout", t, 50);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ch_req_valid = '0;
    @(negedge clk);
    chk(ch_req_ready == '1, "t6_ready", ch_req_ready, 8'hFF);
    chk(ch_done == '0, "t6_done", ch_done, 0);
    chk(wr_req_valid == 1'b0, "t6_valid", wr_req_valid, 0);
    chk(wr_req_last == 1'b0, "t6_last", wr_req_last, 0);
    chk(busy == 1'b0, "t6_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    log_q.delete();
    set_desc(6, 32'hA000, 20);
    wait_idle();
    chk(log_q.size() == 2, "t6_count", log_q.size(), 2);
    chk_log(0, 6, 32'hA000, 15, 0);
    chk_log(1, 6, 32'hA040, 3, 1);

    // Random traffic with random initiator backpressure.
    ready_mode = 1;
    repeat (800) begin
      step();
      if ($urandom_range(0, 3) == 0) begin
        int c;
        logic [31:0] a;
        int unsigned beats;
        c = $urandom_range(0, CH - 1);
        if (!ch_req_valid[c]) begin
          a = {4'h0, 16'($urandom_range(0, 16'hFFFF)), 12'h000};
          if ($urandom_range(0, 1) == 1) a[11:0] = 12'(4096 - 4 * $urandom_range(1, 24));
          else a[11:0] = 12'(4 * $urandom_range(0, 1023));
          beats = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 70);
          set_desc(c, a, beats);
        end
      end
    end
    wait_idle();
    chk(exp_q.size() == 0, "rand_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
